// File: rtl/intr_pkg.sv
// Shared types and constants for the two-line interrupt controller.
// State encoding, vector indices and a priority helper.
package intr_pkg;

   localparam int N_IRQ    = 2;
   localparam int VEC_IRQ0 = 0;
   localparam int VEC_IRQ1 = 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      SERVICE  = 2'd2
   } state_t;

   // One-hot of the lowest set bit; IRQ0 outranks IRQ1.
   function automatic logic [N_IRQ-1:0] lowest_set(input logic [N_IRQ-1:0] v);
      return {v[VEC_IRQ1] & ~v[VEC_IRQ0], v[VEC_IRQ0]};
   endfunction

endpackage

// File: rtl/intr_if.sv
// Request/dispatch bundle between control unit and interrupt controller.
// master = control unit / requester side, slave = intr_ctrl.
interface intr_if;
   import intr_pkg::*;

   logic [N_IRQ-1:0] irq_in;
   logic             irq_en_we;
   logic [N_IRQ-1:0] irq_en_wd;
   logic             fetch_ok;
   logic             reti;
   logic             s_intr1;
   logic             s_intr2;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] in_service;
   logic             busy;

   modport master (
      output irq_in, irq_en_we, irq_en_wd, fetch_ok, reti,
      input  s_intr1, s_intr2, pending, in_service, busy
   );

   modport slave (
      input  irq_in, irq_en_we, irq_en_wd, fetch_ok, reti,
      output s_intr1, s_intr2, pending, in_service, busy
   );

endinterface

// File: rtl/intr_ctrl_irq_sync_edge.sv
// Single-bit multi-stage synchroniser followed by a rising-edge detector.
// rise is high for one cycle per 0->1 transition of the synchronised input.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// Two-line interrupt controller driving the CPU vector selects s_intr1/s_intr2.
// Define INTR_NEST_EN to let IRQ0 preempt an IRQ1 service (depth 2).
import intr_pkg::*;

module intr_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [1:0] IRQ_EN_RST  = 2'b11
) (
   input logic   clk,
   input logic   reset,
   intr_if.slave bus
);

   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] mask;
   logic [N_IRQ-1:0] pend, pend_n, pend_clr;
   logic [N_IRQ-1:0] isr, isr_n;
   logic [N_IRQ-1:0] pulse, pulse_n;
   logic [N_IRQ-1:0] grant;
   state_t           state, state_n;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
      irq_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .reset(reset),
         .d    (bus.irq_in[i]),
         .rise (rise[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mask  <= IRQ_EN_RST;
         pend  <= '0;
         isr   <= '0;
         pulse <= '0;
      end else begin
         state <= state_n;
         pend  <= pend_n;
         isr   <= isr_n;
         pulse <= pulse_n;
         if (bus.irq_en_we) mask <= bus.irq_en_wd;
      end
   end

   always_comb begin
      state_n  = state;
      pend_clr = '0;
      isr_n    = isr;
      pulse_n  = '0;
      grant    = lowest_set(pend & mask);
      unique case (state)
         IDLE: begin
            if (bus.fetch_ok && |grant) begin
               pend_clr = grant;
               isr_n    = isr | grant;
               pulse_n  = grant;
               state_n  = DISPATCH;
            end
         end
         DISPATCH: state_n = SERVICE;
         SERVICE: begin
            if (bus.reti) begin
`ifdef INTR_NEST_EN
               isr_n   = isr & ~lowest_set(isr);
               state_n = (|isr_n) ? SERVICE : IDLE;
`else
               isr_n   = '0;
               state_n = IDLE;
`endif
            end
`ifdef INTR_NEST_EN
            else if (isr == 2'b10 && bus.fetch_ok &&
                     pend[VEC_IRQ0] && mask[VEC_IRQ0]) begin
               pend_clr = 2'b01;
               isr_n    = 2'b11;
               pulse_n  = 2'b01;
               state_n  = DISPATCH;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
      // A new edge wins over a same-cycle dispatch clear.
      pend_n = (pend & ~pend_clr) | rise;
   end

   assign bus.s_intr1    = pulse[VEC_IRQ0];
   assign bus.s_intr2    = pulse[VEC_IRQ1];
   assign bus.pending    = pend;
   assign bus.in_service = isr;
   assign bus.busy       = |isr;

endmodule
